// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: holds the latest byte from each of N_SRC sources and
// rotates the seven-segment display round-robin over the sources that have
// delivered data, showing each for DWELL cycles followed by one NEXT cycle.
// Optional feature macro: SEG_SCHED_PREEMPT_EN. When defined, a strobe from a
// source other than the one on screen takes the display over immediately.
module seg_display_scheduler #(
    parameter  int N_SRC = 2,
    parameter  int DWELL = 50_000_000,
    localparam int SW    = $clog2(N_SRC),
    localparam int CW    = $clog2(DWELL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic                 hold,
    output logic [7:0]           disp_data,
    output logic [SW-1:0]        disp_src,
    output logic                 disp_live,
    output logic                 disp_update
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_NEXT = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Lowest set index of a source vector (0 when none is set).
    function automatic logic [SW-1:0] lowest_set(input logic [N_SRC-1:0] vec);
        logic [SW-1:0] idx;
        idx = {SW{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = vec[i] ? SW'(i) : idx;
        end
        return idx;
    endfunction

    // First seen index after cur, ascending with wrap; cur itself if no other.
    function automatic logic [SW-1:0] next_seen(input logic [SW-1:0]    cur,
                                                input logic [N_SRC-1:0] seen);
        logic [SW-1:0] idx;
        int            cand;
        idx = cur;
        for (int k = N_SRC - 1; k >= 1; k--) begin
            cand = int'(cur) + k;
            cand = (cand >= N_SRC) ? (cand - N_SRC) : cand;
            idx  = seen[cand] ? SW'(cand) : idx;
        end
        return idx;
    endfunction

    logic [7:0]       slot_data_r [N_SRC];
    logic [N_SRC-1:0] slot_seen_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [SW-1:0]    src_nxt_s;
    logic [7:0]       data_nxt_s;
    logic             live_nxt_s;
    logic [N_SRC-1:0] seen_now_s;
    logic             preempt_s;
    logic [SW-1:0]    preempt_src_s;

`ifdef SEG_SCHED_PREEMPT_EN
    logic [N_SRC-1:0] others_s;

    // Strobes from sources other than the one currently on screen.
    always_comb begin
        others_s           = src_valid;
        others_s[disp_src] = 1'b0;
    end

    assign preempt_s     = |others_s;
    assign preempt_src_s = lowest_set(others_s);
`else
    assign preempt_s     = 1'b0;
    assign preempt_src_s = {SW{1'b0}};
`endif

    // Per-source byte store; simultaneous strobes all latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                slot_data_r[i] <= 8'h00;
            end
            slot_seen_r <= {N_SRC{1'b0}};
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid[i]) begin
                    slot_data_r[i] <= src_data[8*i +: 8];
                    slot_seen_r[i] <= 1'b1;
                end
            end
        end
    end

    // Next-state, dwell counter and next display values.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        src_nxt_s   = disp_src;
        data_nxt_s  = 8'h00;
        live_nxt_s  = 1'b0;
        // Include this cycle's strobes so IDLE leaves on the same edge they latch.
        seen_now_s  = slot_seen_r | src_valid;
        case (state_r)
            ST_IDLE: begin
                if (|seen_now_s) begin
                    state_nxt_s = ST_SHOW;
                    src_nxt_s   = lowest_set(seen_now_s);
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                data_nxt_s = slot_data_r[disp_src];
                live_nxt_s = slot_seen_r[disp_src];
                if (preempt_s) begin
                    src_nxt_s = preempt_src_s;
                    cnt_nxt_s = {CW{1'b0}};
                end else if (hold) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_NEXT;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_NEXT: begin
                data_nxt_s  = slot_data_r[disp_src];
                live_nxt_s  = slot_seen_r[disp_src];
                state_nxt_s = ST_SHOW;
                cnt_nxt_s   = {CW{1'b0}};
                if (preempt_s) begin
                    src_nxt_s = preempt_src_s;
                end else begin
                    src_nxt_s = next_seen(disp_src, slot_seen_r);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
                src_nxt_s   = {SW{1'b0}};
            end
        endcase
    end

    // State, counter and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            disp_data   <= 8'h00;
            disp_src    <= {SW{1'b0}};
            disp_live   <= 1'b0;
            disp_update <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            disp_data   <= data_nxt_s;
            disp_src    <= src_nxt_s;
            disp_live   <= live_nxt_s;
            disp_update <= (data_nxt_s != disp_data) || (src_nxt_s != disp_src);
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler (N_SRC=2, DWELL=4) using a
// cycle model whose expected outputs are queued and compared each cycle.
module tb_seg_display_scheduler;

    localparam int DWELL = 4;
`ifdef SEG_SCHED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  src_valid;
    logic [15:0] src_data;
    logic        hold;
    logic [7:0]  disp_data;
    logic        disp_src;
    logic        disp_live;
    logic        disp_update;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       l;
        logic       u;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state (0 idle, 1 show, 2 next).
    int         m_state;
    int         m_cnt;
    logic       m_src;
    logic [7:0] m_data;
    logic       m_live;
    logic       m_upd;
    logic [7:0] m_slot [2];
    logic [1:0] m_seen;

    seg_display_scheduler #(.N_SRC(2), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .hold       (hold),
        .disp_data  (disp_data),
        .disp_src   (disp_src),
        .disp_live  (disp_live),
        .disp_update(disp_update)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_src = 1'b0; m_data = 8'h00;
        m_live = 1'b0; m_upd = 1'b0; m_seen = 2'b00;
        m_slot[0] = 8'h00; m_slot[1] = 8'h00;
        sb_q.delete();
    endtask

    // Advance the model by one clock edge and queue the expected outputs.
    task automatic model_step(input logic [1:0] v, input logic [15:0] d, input logic h);
        int         ns, nc;
        logic       nsrc, other;
        logic [7:0] nd;
        logic       nl;
        logic [1:0] any;
        exp_t       e;
        ns = m_state; nc = m_cnt; nsrc = m_src; nd = 8'h00; nl = 1'b0;
        any = m_seen | v;
        other = ~m_src;
        if (m_state == 0) begin
            if (any != 2'b00) begin
                ns = 1; nc = 0; nsrc = any[0] ? 1'b0 : 1'b1;
            end
        end else begin
            nd = m_slot[m_src];
            nl = m_seen[m_src];
            if (PREEMPT && v[other]) begin
                nsrc = other; nc = 0; ns = 1;
            end else if (m_state == 2) begin
                ns = 1; nc = 0;
                if (m_seen[other]) nsrc = other;
            end else if (!h) begin
                if (m_cnt == DWELL - 1) begin ns = 2; nc = 0; end
                else nc = m_cnt + 1;
            end
        end
        m_upd = (nd != m_data) || (nsrc != m_src);
        m_state = ns; m_cnt = nc; m_src = nsrc; m_data = nd; m_live = nl;
        if (v[0]) begin m_slot[0] = d[7:0];  m_seen[0] = 1'b1; end
        if (v[1]) begin m_slot[1] = d[15:8]; m_seen[1] = 1'b1; end
        e.d = m_data; e.s = m_src; e.l = m_live; e.u = m_upd;
        sb_q.push_back(e);
    endtask

    // One clock: drive at negedge, model the edge, compare at next negedge.
    task automatic cycle(input logic [1:0] v, input logic [15:0] d, input logic h);
        exp_t e;
        src_valid = v; src_data = d; hold = h;
        model_step(v, d, h);
        @(posedge clk);
        @(negedge clk);
        src_valid = 2'b00;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("disp_data",   disp_data,   e.d);
            chk("disp_src",    disp_src,    e.s);
            chk("disp_live",   disp_live,   e.l);
            chk("disp_update", disp_update, e.u);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, disp_data,   8'h00);
        chk({tag, "_src"},  disp_src,    1'b0);
        chk({tag, "_live"}, disp_live,   1'b0);
        chk({tag, "_upd"},  disp_update, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic       held_src;
        logic [7:0] pre_slot0;
        int         n;
        vectors = 0; miscompares = 0;
        rst = 1'b1; src_valid = 2'b00; src_data = 16'h0000; hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (3) cycle(2'b00, 16'h0000, 1'b0);

        // Rotation: both sources loaded in the same cycle.
        cycle(2'b11, {8'h2A, 8'h05}, 1'b0);
        repeat (5) cycle(2'b00, 16'h0000, 1'b0);
        chk("rot_src", disp_src, 1'b1);
        cycle(2'b00, 16'h0000, 1'b0);
        chk("rot_data", disp_data, 8'h2A);
        repeat (16) cycle(2'b00, 16'h0000, 1'b0);

        // Live update of the source on screen.
        n = 0;
        while (!(m_state == 1 && m_src == 1'b1 && m_cnt == 0) && n < 30) begin
            cycle(2'b00, 16'h0000, 1'b0); n++;
        end
        chk("wait_live", n < 30, 1'b1);
        cycle(2'b10, {8'h63, 8'h00}, 1'b0);
        cycle(2'b00, 16'h0000, 1'b0);
        chk("live_data", disp_data, 8'h63);
        chk("live_src",  disp_src,  1'b1);

        // Hold from counter 2 for 20 cycles, with a new byte on the shown source.
        n = 0;
        while (!(m_state == 1 && m_cnt == 2) && n < 30) begin
            cycle(2'b00, 16'h0000, 1'b0); n++;
        end
        chk("wait_hold", n < 30, 1'b1);
        held_src = m_src;
        for (int i = 0; i < 20; i++) begin
            cycle((i == 5) ? (held_src ? 2'b10 : 2'b01) : 2'b00, 16'h8080, 1'b1);
            if (i == 6) chk("hold_data", disp_data, 8'h80);
        end
        chk("hold_src", disp_src, held_src);
        repeat (14) cycle(2'b00, 16'h0000, 1'b0);

        // Strobe on the other source while source 0 is shown at counter 1.
        n = 0;
        while (!(m_state == 1 && m_src == 1'b0 && m_cnt == 1) && n < 30) begin
            cycle(2'b00, 16'h0000, 1'b0); n++;
        end
        chk("wait_pre", n < 30, 1'b1);
        pre_slot0 = m_slot[0];
        cycle(2'b10, {8'h10, 8'h00}, 1'b0);
        chk("pre_src", disp_src, PREEMPT ? 1'b1 : 1'b0);
        cycle(2'b00, 16'h0000, 1'b0);
        chk("pre_data", disp_data, PREEMPT ? 8'h10 : pre_slot0);
        repeat (15) cycle(2'b00, 16'h0000, 1'b0);

        // Reset mid-dwell, then restart from source 1 with a negative byte.
        n = 0;
        while (!(m_state == 1 && m_cnt == 1) && n < 30) begin
            cycle(2'b00, 16'h0000, 1'b0); n++;
        end
        chk("wait_rst", n < 30, 1'b1);
        do_reset("midrst");
        repeat (2) cycle(2'b00, 16'h0000, 1'b0);
        cycle(2'b10, {8'hF6, 8'h00}, 1'b0);
        cycle(2'b00, 16'h0000, 1'b0);
        chk("rst_src",  disp_src,  1'b1);
        chk("rst_data", disp_data, 8'hF6);
        chk("rst_live", disp_live, 1'b1);
        repeat (8) cycle(2'b00, 16'h0000, 1'b0);

        // Single source: rotation must keep reselecting source 0.
        do_reset("single_rst");
        cycle(2'b01, {8'h00, 8'h3C}, 1'b0);
        repeat (12) cycle(2'b00, 16'h0000, 1'b0);
        cycle(2'b01, {8'h00, 8'hC4}, 1'b0);
        repeat (12) cycle(2'b00, 16'h0000, 1'b0);
        chk("single_src",  disp_src,    1'b0);
        chk("single_data", disp_data,   8'hC4);
        chk("single_upd",  disp_update, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
